// File: rtl/shift_reg_pkg.sv
// Shared types for the self-sequencing shift/count unit.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        SHR   = 3'b001,
        SHL   = 3'b010,
        INC   = 3'b011,
        ROR   = 3'b100,
        ROL   = 3'b101,
        ASR   = 3'b110,
        CLEAR = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // LOAD and CLEAR complete at the accepting edge and never repeat.
    function automatic logic is_single_shot(op_e o);
        return (o == LOAD) || (o == CLEAR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One application of an op to the register; purely combinational.
// out_vld_o flags ops that shift or rotate a bit out of the register.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             out_bit_o,
    output logic             out_vld_o
);

    always_comb begin
        nxt_o     = reg_i;
        out_bit_o = 1'b0;
        out_vld_o = 1'b0;
        case (op_e'(op_i))
            LOAD:  nxt_o = load_i;
            SHR: begin
                nxt_o     = {ser_i, reg_i[WIDTH-1:1]};
                out_bit_o = reg_i[0];
                out_vld_o = 1'b1;
            end
            SHL: begin
                nxt_o     = {reg_i[WIDTH-2:0], ser_i};
                out_bit_o = reg_i[WIDTH-1];
                out_vld_o = 1'b1;
            end
            INC:   nxt_o = reg_i + WIDTH'(1);
            ROR: begin
                nxt_o     = {reg_i[0], reg_i[WIDTH-1:1]};
                out_bit_o = reg_i[0];
                out_vld_o = 1'b1;
            end
            ROL: begin
                nxt_o     = {reg_i[WIDTH-2:0], reg_i[WIDTH-1]};
                out_bit_o = reg_i[WIDTH-1];
                out_vld_o = 1'b1;
            end
            ASR: begin
                nxt_o     = {reg_i[WIDTH-1], reg_i[WIDTH-1:1]};
                out_bit_o = reg_i[0];
                out_vld_o = 1'b1;
            end
            CLEAR: nxt_o = '0;
            default: nxt_o = reg_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Shift/count unit: LOAD/CLEAR/zero-count finish at the accepting edge, repeating ops take N+1 cycles to done.
// start is ignored while busy; every output comes straight from a register.
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] data_q;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] data_d;
    logic             ser_d;
    logic             ser_vld;

    // While running, only the latched op drives the step; live op is ignored.
    assign step_op = (state_q == RUN) ? op_q : op;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i      (step_op),
        .reg_i     (data_q),
        .load_i    (data_in),
        .ser_i     (ser_in),
        .nxt_o     (data_d),
        .out_bit_o (ser_d),
        .out_vld_o (ser_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= LOAD;
            rem_q   <= '0;
            data_q  <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_single_shot(op_e'(op))) begin
                            data_q <= data_d;
                            done_q <= 1'b1;
                        end else if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            op_q    <= op_e'(op);
                            rem_q   <= count;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (ser_vld) begin
                        ser_q <= ser_d;
                    end
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomized bench for shift_reg_seq against an arithmetic reference model.
module tb_shift_reg_seq;

    localparam int W    = 8;
    localparam int CW   = $clog2(W + 1);
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  data_in;
    logic [CW-1:0] count;
    logic          ser_in;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_err = 0;
    int m_reg = 0;
    int m_ser = 0;

    always #5 clk = ~clk;

    shift_reg_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .count    (count),
        .ser_in   (ser_in),
        .data_out (data_out),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int exp_busy, input int exp_done);
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_reg));
        chk({tag, ".ser_out"},  32'(ser_out),  32'(m_ser));
        chk({tag, ".busy"},     32'(busy),     32'(exp_busy));
        chk({tag, ".done"},     32'(done),     32'(exp_done));
    endtask

    // Reference: one step of op o with fill bit s, as plain integer arithmetic.
    function automatic void model_step(input int o, input int s);
        int msb;
        int lsb;
        msb = (m_reg >> (W - 1)) & 1;
        lsb = m_reg & 1;
        case (o)
            1: begin m_ser = lsb; m_reg = (m_reg >> 1) | (s << (W - 1)); end
            2: begin m_ser = msb; m_reg = ((m_reg << 1) | s) & MASK; end
            3: m_reg = (m_reg + 1) % (MASK + 1);
            4: begin m_ser = lsb; m_reg = (m_reg >> 1) | (lsb << (W - 1)); end
            5: begin m_ser = msb; m_reg = ((m_reg << 1) | msb) & MASK; end
            6: begin m_ser = lsb; m_reg = (m_reg >> 1) | (msb << (W - 1)); end
            default: ;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_all("idle", 0, 0);
        end
    endtask

    // smode: 0/1 = constant ser_in, 2 = random per step. poke: stray start at step 2.
    // abort_at: assert rst right after that step (0 = never).
    task automatic run_op(input int o, input int n, input int d, input int smode,
                          input bit poke, input int abort_at);
        int s;
        start   = 1'b1;
        op      = 3'(o);
        count   = CW'(n);
        data_in = W'(d);
        ser_in  = (smode == 2) ? 1'($urandom_range(0, 1)) : smode[0];
        tick();
        start   = 1'b0;
        op      = 3'($urandom);
        count   = CW'($urandom);
        data_in = W'($urandom);
        if (o == 0) m_reg = d & MASK;
        else if (o == 7) m_reg = 0;
        if (o == 0 || o == 7 || n == 0) begin
            chk_all("single", 0, 1);
            return;
        end
        chk_all("accept", 1, 0);
        for (int k = 1; k <= n; k++) begin
            s = (smode == 2) ? int'($urandom_range(0, 1)) : (smode & 1);
            ser_in = 1'(s);
            if (poke && k == 2) begin
                start   = 1'b1;
                op      = 3'd7;
                count   = CW'($urandom);
                data_in = W'($urandom);
            end
            tick();
            start = 1'b0;
            model_step(o, s);
            chk_all("step", (k < n) ? 1 : 0, (k == n) ? 1 : 0);
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst   = 1'b0;
                m_reg = 0;
                m_ser = 0;
                chk_all("reset_mid", 0, 0);
                return;
            end
        end
    endtask

    initial begin
        int o;
        int n;
        int ab;
        rst     = 1'b1;
        start   = 1'b0;
        op      = '0;
        data_in = '0;
        count   = '0;
        ser_in  = 1'b0;
        tick();
        tick();
        chk_all("rst_hold", 0, 0);
        rst = 1'b0;
        tick();
        chk_all("rst_release", 0, 0);

        run_op(0, 0, 'hA5, 0, 1'b0, 0);
        chk("load_a5", 32'(data_out), 32'h0000_00A5);
        idle(1);
        run_op(1, 3, 0, 1, 1'b0, 0);
        chk("shr3_final", 32'(data_out), 32'h0000_00F4);
        idle(1);

        run_op(0, 0, 'h81, 0, 1'b0, 0);
        run_op(5, 1, 0, 0, 1'b0, 0);
        chk("rol1", 32'(data_out), 32'h0000_0003);
        chk("rol1_ser", 32'(ser_out), 32'h1);
        run_op(0, 0, 'h81, 0, 1'b0, 0);
        run_op(6, 2, 0, 1, 1'b0, 0);
        chk("asr2", 32'(data_out), 32'h0000_00E0);
        idle(1);

        run_op(0, 0, 'hFE, 0, 1'b0, 0);
        run_op(3, 3, 0, 0, 1'b1, 0);
        chk("inc_wrap", 32'(data_out), 32'h0000_0001);
        idle(1);

        run_op(0, 0, 'h5C, 0, 1'b0, 0);
        run_op(4, W, 0, 0, 1'b0, 0);
        chk("ror_full", 32'(data_out), 32'h0000_005C);
        idle(1);

        run_op(0, 0, 'h0F, 0, 1'b0, 0);
        run_op(2, 5, 0, 0, 1'b0, 2);
        run_op(1, 0, 0, 1, 1'b0, 0);
        chk("cnt0_data", 32'(data_out), 32'h0);
        idle(2);

        for (int i = 0; i < 250; i++) begin
            o  = int'($urandom_range(0, 7));
            n  = int'($urandom_range(0, (1 << CW) - 1));
            ab = (n > 0 && $urandom_range(0, 15) == 0) ? int'($urandom_range(1, n)) : 0;
            run_op(o, n, int'($urandom_range(0, MASK)), 2, ($urandom_range(0, 3) == 0), ab);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
